fwd_hazard_unit: RTL

FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

---
 rtl/fwd_hazard_if.sv | 50 +++++
 rtl/fwd_hazard_unit.sv | 125 ++++++++++++
 2 files changed

// File: rtl/fwd_hazard_if.sv
// rtl/fwd_hazard_if.sv - pipeline signals exchanged with the forwarding/hazard unit
interface fwd_hazard_if #(
    parameter int AW     = 5,
    parameter int NSTAGE = 2
);
    localparam int SW = $clog2(NSTAGE + 1);

    logic [AW-1:0]        rs_ID;
    logic [AW-1:0]        rt_ID;
    logic [AW-1:0]        rs_EX;
    logic [AW-1:0]        rt_EX;
    logic [AW-1:0]        wa_EX;
    logic                 RegWr_EX;
    logic                 MemRd_EX;
    logic                 ALUSrc_EX;
    logic                 useshamt_EX;
    logic                 JumpReg_EX;
    logic                 muldiv_EX;
    logic [NSTAGE*AW-1:0] wa_stg;
    logic [NSTAGE-1:0]    we_stg;
    logic                 flush;

    logic [SW-1:0]        ALUsrcA;
    logic [SW-1:0]        ALUsrcB;
    logic [SW-1:0]        JumpRegSrc;
    logic [SW-1:0]        MemWrSrc;
    logic                 stall_IF;
    logic                 stall_ID;
    logic                 stall_EX;
    logic                 bubble_EX;
    logic                 md_busy;
    logic                 md_done;
    logic [31:0]          stall_cnt;

    modport master (
        output rs_ID, rt_ID, rs_EX, rt_EX, wa_EX,
        output RegWr_EX, MemRd_EX, ALUSrc_EX, useshamt_EX, JumpReg_EX, muldiv_EX,
        output wa_stg, we_stg, flush,
        input  ALUsrcA, ALUsrcB, JumpRegSrc, MemWrSrc,
        input  stall_IF, stall_ID, stall_EX, bubble_EX, md_busy, md_done, stall_cnt
    );

    modport slave (
        input  rs_ID, rt_ID, rs_EX, rt_EX, wa_EX,
        input  RegWr_EX, MemRd_EX, ALUSrc_EX, useshamt_EX, JumpReg_EX, muldiv_EX,
        input  wa_stg, we_stg, flush,
        output ALUsrcA, ALUsrcB, JumpRegSrc, MemWrSrc,
        output stall_IF, stall_ID, stall_EX, bubble_EX, md_busy, md_done, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding selects, load-use and mul/div stall control
module fwd_hazard_unit #(
    parameter int AW     = 5,
    parameter int NSTAGE = 2,
    parameter int MD_LAT = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    fwd_hazard_if.slave bus
);
    localparam int SW = $clog2(NSTAGE + 1);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MD_BUSY = 2'd1,
        MD_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [7:0]    r_md_cnt;
    logic [7:0]    w_md_cnt_nxt;
    logic [31:0]   r_stall_cnt;

    logic [SW-1:0] w_sel_rs;
    logic [SW-1:0] w_sel_rt;
    logic          w_lu;
    logic          w_stall_if;
    logic          w_stall_id;
    logic          w_stall_ex;
    logic          w_bubble;
    logic          w_busy;
    logic          w_done;

    // Walk from the farthest stage down so the nearest match is written last.
    always_comb begin
        w_sel_rs = '0;
        w_sel_rt = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (bus.we_stg[k-1] && (bus.wa_stg[k*AW-1 -: AW] == bus.rs_EX) && (bus.rs_EX != '0))
                w_sel_rs = SW'(k);
            if (bus.we_stg[k-1] && (bus.wa_stg[k*AW-1 -: AW] == bus.rt_EX) && (bus.rt_EX != '0))
                w_sel_rt = SW'(k);
        end
    end

    assign bus.ALUsrcA    = bus.useshamt_EX ? '0 : w_sel_rs;
    assign bus.ALUsrcB    = bus.ALUSrc_EX   ? '0 : w_sel_rt;
    assign bus.JumpRegSrc = bus.JumpReg_EX  ? w_sel_rs : '0;
    assign bus.MemWrSrc   = w_sel_rt;

    assign w_lu = bus.MemRd_EX && bus.RegWr_EX && (bus.wa_EX != '0) &&
                  ((bus.wa_EX == bus.rs_ID) || (bus.wa_EX == bus.rt_ID));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= RUN;
            r_md_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_md_cnt <= w_md_cnt_nxt;
        end
    end

    // The entry cycle counts as the first stall, so MD_BUSY leaves one cycle early.
    always_comb begin
        w_state_nxt  = r_state;
        w_md_cnt_nxt = r_md_cnt;
        w_stall_if   = 1'b0;
        w_stall_id   = 1'b0;
        w_stall_ex   = 1'b0;
        w_bubble     = 1'b0;
        w_busy       = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            RUN: begin
                w_bubble = bus.flush;
                if (bus.muldiv_EX) begin
                    w_state_nxt  = MD_BUSY;
                    w_md_cnt_nxt = 8'(MD_LAT - 1);
                    w_stall_if   = 1'b1;
                    w_stall_id   = 1'b1;
                    w_stall_ex   = 1'b1;
                end else if (w_lu) begin
                    w_stall_if = 1'b1;
                    w_stall_id = 1'b1;
                    w_bubble   = 1'b1;
                end
            end
            MD_BUSY: begin
                w_stall_if   = 1'b1;
                w_stall_id   = 1'b1;
                w_stall_ex   = 1'b1;
                w_busy       = 1'b1;
                w_md_cnt_nxt = (r_md_cnt == 8'd0) ? 8'd0 : r_md_cnt - 8'd1;
                if (r_md_cnt <= 8'd1)
                    w_state_nxt = MD_DONE;
            end
            MD_DONE: begin
                w_done      = 1'b1;
                w_state_nxt = RUN;
            end
            default: begin
                w_state_nxt  = RUN;
                w_md_cnt_nxt = '0;
            end
        endcase
    end

    assign bus.stall_IF  = rst_n & w_stall_if;
    assign bus.stall_ID  = rst_n & w_stall_id;
    assign bus.stall_EX  = rst_n & w_stall_ex;
    assign bus.bubble_EX = rst_n & w_bubble;
    assign bus.md_busy   = rst_n & w_busy;
    assign bus.md_done   = rst_n & w_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_stall_cnt <= '0;
        else if (w_stall_if && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign bus.stall_cnt = r_stall_cnt;
endmodule
